pcileech_perst_sup: RTL

Parametrised PCIe reset supervisor between the board pins and the FIFO/PCIe cores. It merges NUM_CH present/PERST# input pairs and debounces the power-switch / Thunderbolt-detect input. It generates a software reset (rst_sw) in three modes: disabled, legacy one-shot, or continuous monitor with a minimum reset hold and host-requested reset cycles. The block sits in the top level and drives pcie_present and pcie_perst_n into pcileech_fifo and the PCIe core.

---
 rtl/pcileech_perst_sup.sv | 113 +++++++++++
 1 files changed

// File: rtl/pcileech_perst_sup.sv
// PCIe reset supervisor: merges per-channel present/PERST# pins and drives a
// software reset from a debounced power-switch detect and host reset requests.
module pcileech_perst_sup #(
  parameter int              NUM_CH         = 2,
  parameter int              POWER_SW_MODE  = 0,
  parameter longint unsigned POWER_SW_TIME  = 64'd7_500_000_000,
  parameter int unsigned     DEBOUNCE_TICKS = 1_250_000,
  parameter int unsigned     MIN_RST_TICKS  = 12_500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] pcie_present_in,
  input  logic [NUM_CH-1:0] pcie_perst_n_in,
  input  logic              power_sw,
  input  logic              sw_rst_req,
  output logic              pcie_present,
  output logic              pcie_perst_n,
  output logic              rst_sw,
  output logic [1:0]        sup_state,
  output logic [7:0]        rst_count
);

  localparam logic [39:0] SW_LAST   = 40'(POWER_SW_TIME - 64'd1);
  localparam logic [39:0] HOLD_LAST = 40'(MIN_RST_TICKS - 32'd1);
  localparam logic [31:0] DB_LAST   = DEBOUNCE_TICKS - 32'd1;
  localparam bit          MODE_OFF  = (POWER_SW_MODE == 0);
  localparam bit          MODE_MON  = (POWER_SW_MODE == 2);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [39:0] timer_q, timer_d;
  logic [31:0] db_cnt_q, db_cnt_d;
  logic        sw_meta_q, sw_meta_d;
  logic        sw_s_q, sw_s_d;
  logic        sw_db_q, sw_db_d;
  logic        rst_sw_q, rst_sw_d;
  logic [7:0]  rst_count_q, rst_count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      timer_q     <= '0;
      db_cnt_q    <= '0;
      sw_meta_q   <= 1'b0;
      sw_s_q      <= 1'b0;
      sw_db_q     <= 1'b0;
      rst_sw_q    <= 1'b0;
      rst_count_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      db_cnt_q    <= db_cnt_d;
      sw_meta_q   <= sw_meta_d;
      sw_s_q      <= sw_s_d;
      sw_db_q     <= sw_db_d;
      rst_sw_q    <= rst_sw_d;
      rst_count_q <= rst_count_d;
    end
  end

  // Synchroniser and debouncer: sw_db only follows sw_s after DEBOUNCE_TICKS stable cycles.
  always_comb begin
    sw_meta_d = power_sw;
    sw_s_d    = sw_meta_q;
    sw_db_d   = sw_db_q;
    db_cnt_d  = '0;
    if (sw_s_q != sw_db_q) begin
      if (db_cnt_q == DB_LAST) sw_db_d = sw_s_q;
      else                     db_cnt_d = db_cnt_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        if (MODE_OFF)                state_d = ST_RUN;
        else if (timer_q == SW_LAST) state_d = sw_db_q ? ST_RUN : ST_WAIT;
      end
      ST_RUN: begin
        // Loss of the switch outranks a simultaneous host request.
        if (MODE_MON && !sw_db_q) state_d = ST_WAIT;
        else if (sw_rst_req)      state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (timer_q == HOLD_LAST) state_d = (MODE_MON && !sw_db_q) ? ST_WAIT : ST_RUN;
      end
      ST_WAIT: begin
        if (MODE_MON && sw_db_q) state_d = ST_HOLD;
      end
      default: state_d = ST_INIT;
    endcase

    timer_d     = (state_d != state_q) ? '0 : timer_q + 40'd1;
    rst_sw_d    = (state_d == ST_HOLD) || (state_d == ST_WAIT);
    rst_count_d = rst_count_q;
    if ((state_d != state_q) && rst_sw_d && (rst_count_q != 8'hFF))
      rst_count_d = rst_count_q + 8'd1;
  end

  assign rst_sw       = rst_sw_q;
  assign sup_state    = state_q;
  assign rst_count    = rst_count_q;
  assign pcie_present = &pcie_present_in;
  assign pcie_perst_n = (&pcie_perst_n_in) & ~rst_sw_q;

endmodule
